uart_frame_decoder: RTL and testbench

Byte-stream deframer sitting directly downstream of the UART receiver: consumes its one-cycle `rx_valid`/`rx_data` byte strobes, hunts for a sync byte, collects a length-prefixed payload, checks an XOR checksum and, only for good frames, replays the payload on a valid/ready stream. Errored frames are discarded and reported by single-cycle error pulses. An inter-byte timeout, counted on the shared baud `tick`, recovers from truncated frames.

---
 rtl/uart_frame_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
//
// Deframer that sits after a UART receiver. It hunts for SYNC_BYTE and reads
// a length byte L (1..MAX_LEN). It then collects L payload bytes and checks an
// XOR checksum over L and the payload. Only frames that pass the check are
// replayed on a valid/ready stream. Every error is reported as a one-cycle
// pulse. An inter-byte timeout, counted on the baud tick, abandons frames
// that are cut short.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   tick_i         baud tick strobe (shared with the receiver)
//   rx_data_i      received byte
//   rx_valid_i     one-cycle strobe qualifying rx_data_i
//   out_data_o     payload byte (8'h00 outside DRAIN)
//   out_valid_o    payload byte available
//   out_ready_i    consumer accepts the byte
//   out_last_o     final payload byte of the frame
//   frame_ok_o     pulse: checksum matched, drain starts
//   err_len_o      pulse: length 0 or larger than MAX_LEN
//   err_chk_o      pulse: checksum mismatch
//   err_timeout_o  pulse: inter-byte timeout inside a frame
//   err_overrun_o  pulse: byte received while draining (dropped)
//   busy_o         decoder is anywhere other than HUNT
module uart_frame_decoder #(
    parameter int unsigned MAX_LEN       = 16,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned TIMEOUT_TICKS = 160
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       out_last_o,
    output logic       frame_ok_o,
    output logic       err_len_o,
    output logic       err_chk_o,
    output logic       err_timeout_o,
    output logic       err_overrun_o,
    output logic       busy_o
);

    localparam int unsigned PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_e;

    state_e        state_q;
    logic [7:0]    len_q;
    logic [7:0]    chk_q;
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [TW-1:0] tcnt_q;
    logic [7:0]    out_data_q;
    logic          out_last_q;
    logic          frame_ok_q;
    logic          err_len_q;
    logic          err_chk_q;
    logic          err_timeout_q;
    logic          err_overrun_q;

    logic [7:0]    mem_q [MAX_LEN];

    logic [7:0]    len_m1;
    logic [7:0]    chk_d;
    logic [PW-1:0] wptr_d;
    logic [PW-1:0] rptr_d;
    logic          wptr_last;
    logic          rptr_d_last;
    logic          timing_st;

    assign len_m1      = len_q - 8'd1;
    assign chk_d       = chk_q ^ rx_data_i;
    assign wptr_d      = wptr_q + PW'(1);
    assign rptr_d      = rptr_q + PW'(1);
    assign wptr_last   = (8'(wptr_q) == len_m1);
    assign rptr_d_last = (8'(rptr_d) == len_m1);
    // The timeout only runs while a frame is still arriving.
    assign timing_st   = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);

    // The payload buffer has no reset. Its contents are only read after being
    // written by the current frame.
    always_ff @(posedge clk_i) begin
        if (state_q == S_PAYLOAD && rx_valid_i) begin
            mem_q[wptr_q] <= rx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_HUNT;
            len_q         <= 8'd0;
            chk_q         <= 8'd0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            tcnt_q        <= '0;
            out_data_q    <= 8'h00;
            out_last_q    <= 1'b0;
            frame_ok_q    <= 1'b0;
            err_len_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            frame_ok_q    <= 1'b0;
            err_len_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;

            // A byte always wins over a coincident tick. The count restarts
            // from zero and is not incremented.
            // The case below changes state only on rx_valid_i, so the timeout
            // branch can never conflict with it.
            if (rx_valid_i) begin
                tcnt_q <= '0;
            end else if (timing_st && tick_i) begin
                if (tcnt_q == TO_LAST) begin
                    err_timeout_q <= 1'b1;
                    state_q       <= S_HUNT;
                    tcnt_q        <= '0;
                end else begin
                    tcnt_q <= tcnt_q + TW'(1);
                end
            end

            case (state_q)
                S_HUNT: begin
                    if (rx_valid_i && rx_data_i == SYNC_BYTE) begin
                        state_q <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_valid_i) begin
                        if (rx_data_i == 8'd0 || 32'(rx_data_i) > MAX_LEN) begin
                            err_len_q <= 1'b1;
                            state_q   <= S_HUNT;
                        end else begin
                            len_q   <= rx_data_i;
                            chk_q   <= rx_data_i;
                            wptr_q  <= '0;
                            state_q <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_valid_i) begin
                        chk_q <= chk_d;
                        // Hold the pointer on the last byte so it never wraps.
                        if (wptr_last) begin
                            state_q <= S_CHK;
                        end else begin
                            wptr_q <= wptr_d;
                        end
                    end
                end
                S_CHK: begin
                    if (rx_valid_i) begin
                        if (rx_data_i == chk_q) begin
                            // Preload the first byte so that data is valid in
                            // the same cycle as frame_ok.
                            frame_ok_q <= 1'b1;
                            rptr_q     <= '0;
                            out_data_q <= mem_q[0];
                            out_last_q <= (len_q == 8'd1);
                            state_q    <= S_DRAIN;
                        end else begin
                            err_chk_q <= 1'b1;
                            state_q   <= S_HUNT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rx_valid_i) begin
                        err_overrun_q <= 1'b1;
                    end
                    if (out_ready_i) begin
                        if (out_last_q) begin
                            out_data_q <= 8'h00;
                            out_last_q <= 1'b0;
                            rptr_q     <= '0;
                            state_q    <= S_HUNT;
                        end else begin
                            rptr_q     <= rptr_d;
                            out_data_q <= mem_q[rptr_d];
                            out_last_q <= rptr_d_last;
                        end
                    end
                end
                default: begin
                    state_q <= S_HUNT;
                end
            endcase
        end
    end

    assign out_data_o    = out_data_q;
    assign out_last_o    = out_last_q;
    assign out_valid_o   = (state_q == S_DRAIN);
    assign busy_o        = (state_q != S_HUNT);
    assign frame_ok_o    = frame_ok_q;
    assign err_len_o     = err_len_q;
    assign err_chk_o     = err_chk_q;
    assign err_timeout_o = err_timeout_q;
    assign err_overrun_o = err_overrun_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Testbench for uart_frame_decoder.
module tb_uart_frame_decoder;

    logic       clk;
    logic       rstN;
    logic       tick;
    logic [7:0] rxData;
    logic       rxValid;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic       outLast;
    logic       frameOk;
    logic       errLen;
    logic       errChk;
    logic       errTimeout;
    logic       errOverrun;
    logic       busy;
    logic [4:0] pulses;

    int errorCount = 0;
    int checkCount = 0;

    logic [7:0] expBytes [16];

    typedef struct {
        logic [7:0] rxData;
        logic       expBusy;
        logic [4:0] expPulses;
    } vec_t;

    vec_t vecs [14];

    assign pulses = {frameOk, errLen, errChk, errTimeout, errOverrun};

    uart_frame_decoder #(
        .MAX_LEN      (16),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_TICKS(160)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .tick_i       (tick),
        .rx_data_i    (rxData),
        .rx_valid_i   (rxValid),
        .out_data_o   (outData),
        .out_valid_o  (outValid),
        .out_ready_i  (outReady),
        .out_last_o   (outLast),
        .frame_ok_o   (frameOk),
        .err_len_o    (errLen),
        .err_chk_o    (errChk),
        .err_timeout_o(errTimeout),
        .err_overrun_o(errOverrun),
        .busy_o       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not complete, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    task automatic checkPulses(input string name, input logic [4:0] expected);
        checkCount++;
        if (pulses !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: pulses {ok,len,chk,to,ov} got %b expected %b", name, pulses, expected);
        end
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic withTick);
        rxData  = data;
        rxValid = 1'b1;
        tick    = withTick;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
        tick    = 1'b0;
        rxData  = 8'h00;
    endtask

    task automatic tickRun(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(posedge clk);
            #1;
            tick = 1'b0;
            if (errTimeout === 1'b1) seen++;
            @(posedge clk);
            #1;
            if (errTimeout === 1'b1) seen++;
        end
    endtask

    // Expects the first payload byte to be on the outputs already and
    // out_ready to be held high.
    task automatic checkDrain(input int n, input logic firstOk);
        for (int i = 0; i < n; i++) begin
            checkFlag("drain valid", outValid, 1'b1);
            checkOutput("drain data", outData, expBytes[i]);
            checkFlag("drain last", outLast, (i == n - 1));
            checkFlag("drain frame_ok", frameOk, (i == 0) && firstOk);
            idleCycle();
        end
        checkFlag("drain end valid", outValid, 1'b0);
        checkFlag("drain end busy", busy, 1'b0);
        checkOutput("drain end data", outData, 8'h00);
        checkFlag("drain end last", outLast, 1'b0);
    endtask

    initial begin
        int seen;

        rstN     = 1'b1;
        tick     = 1'b0;
        rxData   = 8'h00;
        rxValid  = 1'b0;
        outReady = 1'b1;

        vecs[0]  = '{8'h00, 1'b0, 5'b00000};
        vecs[1]  = '{8'hFF, 1'b0, 5'b00000};
        vecs[2]  = '{8'hA5, 1'b1, 5'b00000};
        vecs[3]  = '{8'h00, 1'b0, 5'b01000};
        vecs[4]  = '{8'hA5, 1'b1, 5'b00000};
        vecs[5]  = '{8'h11, 1'b0, 5'b01000};
        vecs[6]  = '{8'hA5, 1'b1, 5'b00000};
        vecs[7]  = '{8'hA5, 1'b0, 5'b01000};
        vecs[8]  = '{8'hA5, 1'b1, 5'b00000};
        vecs[9]  = '{8'h03, 1'b1, 5'b00000};
        vecs[10] = '{8'h11, 1'b1, 5'b00000};
        vecs[11] = '{8'h22, 1'b1, 5'b00000};
        vecs[12] = '{8'h33, 1'b1, 5'b00000};
        vecs[13] = '{8'h04, 1'b0, 5'b00100};

        // Reset values
        #3 rstN = 1'b0;
        idleCycle();
        idleCycle();
        checkFlag("reset valid", outValid, 1'b0);
        checkOutput("reset data", outData, 8'h00);
        checkFlag("reset last", outLast, 1'b0);
        checkFlag("reset busy", busy, 1'b0);
        checkPulses("reset pulses", 5'b00000);
        rstN = 1'b1;
        idleCycle();

        // Good frame A5 03 11 22 33 03
        $display("[TB] good 3-byte frame");
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        checkFlag("pre-chk valid", outValid, 1'b0);
        applyStimulus(8'h03, 1'b0);
        checkPulses("good frame pulses", 5'b10000);
        expBytes[0] = 8'h11;
        expBytes[1] = 8'h22;
        expBytes[2] = 8'h33;
        checkDrain(3, 1'b1);

        // Garbage, length errors and a bad checksum
        $display("[TB] vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rxData, 1'b0);
            checkFlag($sformatf("vec%0d busy", i), busy, vecs[i].expBusy);
            checkPulses($sformatf("vec%0d pulses", i), vecs[i].expPulses);
            checkFlag($sformatf("vec%0d valid", i), outValid, 1'b0);
        end

        // Maximum length frame: payload 01..10, XOR of L and payload is 00
        $display("[TB] 16-byte frame");
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h10, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i + 1), 1'b0);
            expBytes[i] = 8'(i + 1);
        end
        applyStimulus(8'h00, 1'b0);
        checkPulses("len16 pulses", 5'b10000);
        checkDrain(16, 1'b1);

        // Timeout on the 160th tick of silence
        $display("[TB] timeout");
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h11, 1'b0);
        tickRun(159, seen);
        checkOutput("timeout early", 8'(seen), 8'd0);
        checkFlag("timeout busy before", busy, 1'b1);
        tick = 1'b1;
        idleCycle();
        tick = 1'b0;
        checkPulses("timeout pulse", 5'b00010);
        checkFlag("timeout busy after", busy, 1'b0);
        idleCycle();
        checkFlag("timeout single", errTimeout, 1'b0);

        // A byte coincident with tick 159 restarts the count
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h11, 1'b0);
        tickRun(158, seen);
        applyStimulus(8'h22, 1'b1);
        checkPulses("coincident pulses", 5'b00000);
        tickRun(159, seen);
        checkOutput("restart early", 8'(seen), 8'd0);
        checkFlag("restart busy", busy, 1'b1);
        tick = 1'b1;
        idleCycle();
        tick = 1'b0;
        checkPulses("restart timeout", 5'b00010);
        checkFlag("restart busy after", busy, 1'b0);

        // Backpressure and overrun: A5 03 AA 55 0F, check byte F3
        $display("[TB] backpressure");
        outReady = 1'b0;
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'h55, 1'b0);
        applyStimulus(8'h0F, 1'b0);
        applyStimulus(8'hF3, 1'b0);
        checkPulses("bp frame_ok", 5'b10000);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) applyStimulus(8'hA5, 1'b0);
            else if (c == 3) applyStimulus(8'h00, 1'b0);
            else idleCycle();
            checkFlag($sformatf("hold%0d overrun", c), errOverrun, (c == 1) || (c == 3));
            checkFlag($sformatf("hold%0d valid", c), outValid, 1'b1);
            checkOutput($sformatf("hold%0d data", c), outData, 8'hAA);
            checkFlag($sformatf("hold%0d last", c), outLast, 1'b0);
        end
        outReady = 1'b1;
        expBytes[0] = 8'hAA;
        expBytes[1] = 8'h55;
        expBytes[2] = 8'h0F;
        checkDrain(3, 1'b0);

        // Garbage then a one-byte frame
        $display("[TB] garbage and one-byte frame");
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h7F, 1'b0);
        expBytes[0] = 8'h7E;
        checkDrain(1, 1'b1);

        // Reset mid-frame
        $display("[TB] reset mid-frame");
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h11, 1'b0);
        #2 rstN = 1'b0;
        #1;
        checkFlag("rst frame busy", busy, 1'b0);
        checkPulses("rst frame pulses", 5'b00000);
        idleCycle();
        rstN = 1'b1;
        idleCycle();
        checkPulses("post rst pulses", 5'b00000);
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h31, 1'b0);
        expBytes[0] = 8'h11;
        expBytes[1] = 8'h22;
        checkDrain(2, 1'b1);

        // Reset mid-drain drops out_valid without waiting for a clock
        $display("[TB] reset mid-drain");
        outReady = 1'b0;
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h5A, 1'b0);
        applyStimulus(8'h5B, 1'b0);
        checkFlag("pre-rst valid", outValid, 1'b1);
        checkOutput("pre-rst data", outData, 8'h5A);
        checkFlag("pre-rst last", outLast, 1'b1);
        #2 rstN = 1'b0;
        #1;
        checkFlag("rst drain valid", outValid, 1'b0);
        checkOutput("rst drain data", outData, 8'h00);
        checkFlag("rst drain busy", busy, 1'b0);
        checkPulses("rst drain pulses", 5'b00000);
        idleCycle();
        rstN = 1'b1;
        outReady = 1'b1;
        idleCycle();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
